// File: rtl/fp_mul_normalizer.sv
// fp_mul_normalizer: post-multiply normalize/round stage of the FP multiplier.
// Takes the raw mantissa product plus operand signs/exponents and produces a
// packed {sign, exponent, fraction} result with overflow/underflow flags.
// Sequence: IDLE (latch) -> ALIGN (1-bit right shift) -> NORM (left shifts)
// -> ROUND (round, range check, register result).
// Build option: define FPMUL_ROUND_EN for round-to-nearest-even; otherwise
// the fraction is truncated (same latency either way).
module fp_mul_normalizer #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     sign_a,
  input  logic                     sign_b,
  input  logic [EXP_W-1:0]         exp_a,
  input  logic [EXP_W-1:0]         exp_b,
  input  logic [2*(MAN_W+1)-1:0]   prod,
  output logic                     out_valid,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = 2 * (MAN_W + 1);
  localparam int RW = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;

  localparam logic signed [EW-1:0] BIAS = EW'(2 ** (EXP_W - 1) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'(2 ** EXP_W - 1);
  localparam logic signed [EW-1:0] ONE  = EW'(1);

`ifdef FPMUL_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ALIGN, NORM, ROUND} state_t;

  state_t                 state;
  logic [PW-1:0]          m;
  logic signed [EW-1:0]   e;
  logic                   sgn;
  logic                   zero;
  logic                   stk;

  logic [MAN_W:0]         rnd;
  logic signed [EW-1:0]   e_rnd;

  // Round-to-nearest-even on the normalized mantissa (hidden bit stripped).
  // Returns {carry, fraction}; on carry the fraction bits are already zero.
  function automatic logic [MAN_W:0] round_frac(input logic [PW-3:0] mv,
                                                input logic sticky);
    logic [MAN_W-1:0] f;
    logic             g;
    logic             s;
    logic             inc;
    f   = mv[PW-3 -: MAN_W];
    g   = mv[PW-3-MAN_W];
    s   = (|mv[PW-4-MAN_W:0]) | sticky;
    inc = ROUND_EN & g & (s | f[0]);
    return {1'b0, f} + {{MAN_W{1'b0}}, inc};
  endfunction

  // Range check and packing; returns {result, overflow, underflow}.
  function automatic logic [RW+1:0] pack_result(input logic s,
                                                input logic z,
                                                input logic signed [EW-1:0] ev,
                                                input logic [MAN_W-1:0] f);
    if (z)
      return {s, {(RW-1){1'b0}}, 2'b00};
    else if (ev >= EMAX)
      return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}, 2'b10};
    else if (ev <= 0)
      return {s, {(RW-1){1'b0}}, 2'b01};
    else
      return {s, ev[EXP_W-1:0], f, 2'b00};
  endfunction

  assign rnd   = round_frac(m[PW-3:0], stk);
  assign e_rnd = e + signed'({{(EW-1){1'b0}}, rnd[MAN_W]});

  // Control FSM with registered handshake, result and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= ALIGN;
            in_ready <= 1'b0;
          end
        end
        ALIGN: begin
          if (zero || m[PW-1] || m[PW-2])
            state <= ROUND;
          else
            state <= NORM;
        end
        NORM: begin
          // the shift happening on this edge brings the hidden bit into place
          if (m[PW-3])
            state <= ROUND;
        end
        ROUND: begin
          {result, overflow, underflow} <= pack_result(sgn, zero, e_rnd, rnd[MAN_W-1:0]);
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Working mantissa/exponent datapath; not reset, qualified by the FSM state.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (in_valid) begin
          m    <= prod;
          sgn  <= sign_a ^ sign_b;
          e    <= signed'({2'b00, exp_a}) + signed'({2'b00, exp_b}) - BIAS;
          zero <= (exp_a == '0) | (exp_b == '0) | (prod == '0);
          stk  <= 1'b0;
        end
      end
      ALIGN: begin
        if (!zero && m[PW-1]) begin
          m   <= m >> 1;
          stk <= m[0];
          e   <= e + ONE;
        end
      end
      NORM: begin
        m <= m << 1;
        e <= e - ONE;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fp_mul_normalizer.sv
// Testbench for fp_mul_normalizer (single precision defaults).
// A reference model computes each expected result from the leading-one
// position of the product; a monitor compares every out_valid pulse, its
// latency and in_ready against the model. Literal values pin the model.
module tb_fp_mul_normalizer;

`ifdef FPMUL_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign_a = 1'b0, sign_b = 1'b0;
  logic [7:0]  exp_a = '0, exp_b = '0;
  logic [47:0] prod = '0;
  logic        out_valid;
  logic [31:0] result;
  logic        overflow, underflow;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] res;
    logic        ov;
    logic        un;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];

  fp_mul_normalizer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sign_a(sign_a), .sign_b(sign_b), .exp_a(exp_a), .exp_b(exp_b),
    .prod(prod), .out_valid(out_valid), .result(result),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Reference: normalize the product so the hidden bit sits at bit 46,
  // then round/truncate and range-check with plain integer arithmetic.
  function automatic void model(input logic sa, input logic sb,
                                input logic [7:0] ea, input logic [7:0] eb,
                                input logic [47:0] p,
                                output logic [31:0] res, output logic ov,
                                output logic un, output int lat);
    int          ex;
    int          pos;
    logic [63:0] mm;
    logic        sticky;
    logic [31:0] frac;
    logic        g, s;
    res = '0; ov = 1'b0; un = 1'b0; lat = 2;
    if (ea == 0 || eb == 0 || p == 0) begin
      res = {sa ^ sb, 31'b0};
      return;
    end
    ex = int'(ea) + int'(eb) - 127;
    pos = 0;
    for (int i = 0; i < 48; i++) if (p[i]) pos = i;
    sticky = 1'b0;
    if (pos == 47) begin
      sticky = p[0];
      mm = {16'b0, p} >> 1;
      ex = ex + 1;
    end else begin
      mm = {16'b0, p} << (46 - pos);
      ex = ex - (46 - pos);
      lat = 2 + 46 - pos;
    end
    frac = 32'(mm >> 23) & 32'h007F_FFFF;
    g = mm[22];
    s = (mm[21:0] != 0) || sticky;
    if (RND && g && (s || frac[0])) frac = frac + 1;
    if (frac == 32'h0080_0000) begin
      frac = 0;
      ex = ex + 1;
    end
    if (ex >= 255) begin
      res = {sa ^ sb, 8'hFF, 23'b0};
      ov = 1'b1;
    end else if (ex <= 0) begin
      res = {sa ^ sb, 31'b0};
      un = 1'b1;
    end else begin
      res = {sa ^ sb, 8'(ex), frac[22:0]};
    end
  endfunction

  // Compare process: checks every result pulse and in_ready while busy.
  always @(posedge clk) begin
    exp_t ex;
    #1;
    cyc++;
    if (out_valid) begin
      chk("valid_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        ex = q.pop_front();
        chk("result", 64'(result), 64'(ex.res));
        chk("overflow", 64'(overflow), 64'(ex.ov));
        chk("underflow", 64'(underflow), 64'(ex.un));
        chk("latency", 64'(cyc - ex.acc), 64'(ex.lat));
      end
    end else if (q.size() > 0 && cyc >= q[0].acc) begin
      chk("in_ready_busy", 64'(in_ready), 64'd0);
    end
  end

  // Issue one operation at a negedge; optionally pin the model to literals.
  task automatic run_op(input logic sa, input logic sb, input logic [7:0] ea,
                        input logic [7:0] eb, input logic [47:0] p,
                        input bit has_lit, input logic [31:0] lres,
                        input logic lov, input logic lun, input int llat);
    exp_t ex;
    int   n;
    model(sa, sb, ea, eb, p, ex.res, ex.ov, ex.un, ex.lat);
    if (has_lit) begin
      chk("model_result", 64'(ex.res), 64'(lres));
      chk("model_flags", 64'({ex.ov, ex.un}), 64'({lov, lun}));
      chk("model_latency", 64'(ex.lat), 64'(llat));
    end
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'd1);
    sign_a = sa; sign_b = sb; exp_a = ea; exp_b = eb; prod = p;
    in_valid = 1'b1;
    ex.acc = cyc + 1;
    q.push_back(ex);
    @(negedge clk);
    in_valid = 1'b0;
    prod = 48'h5A5A_5A5A_5A5A;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", 64'({result, overflow, underflow}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(0, 0, 8'd127, 8'd127, 48'h9000_0000_0000, 1, 32'h4010_0000, 0, 0, 2);
    run_op(1, 0, 8'd0, 8'd130, 48'h1234_5678_9ABC, 1, 32'h8000_0000, 0, 0, 2);
    run_op(0, 0, 8'd254, 8'd254, 48'h4000_0000_0000, 1, 32'h7F80_0000, 1, 0, 2);
    run_op(0, 0, 8'd1, 8'd1, 48'h4000_0000_0000, 1, 32'h0000_0000, 0, 1, 2);
    run_op(0, 0, 8'd127, 8'd127, 48'h4000_01C0_0000, 1,
           RND ? 32'h3F80_0004 : 32'h3F80_0003, 0, 0, 2);
    run_op(0, 0, 8'd127, 8'd127, 48'h7FFF_FFC0_0000, 1,
           RND ? 32'h4000_0000 : 32'h3FFF_FFFF, 0, 0, 2);
    run_op(0, 0, 8'd127, 8'd127, 48'h4000_0040_0000, 1, 32'h3F80_0000, 0, 0, 2);
    run_op(1, 0, 8'd127, 8'd127, 48'h8000_0080_0001, 1,
           RND ? 32'hC000_0001 : 32'hC000_0000, 0, 0, 2);
    run_op(0, 0, 8'd254, 8'd127, 48'h7FFF_FFC0_0000, 1,
           RND ? 32'h7F80_0000 : 32'h7F7F_FFFF, RND, 0, 2);
    run_op(0, 0, 8'd1, 8'd127, 48'h4000_0000_0000, 1, 32'h0080_0000, 0, 0, 2);
    run_op(0, 0, 8'd200, 8'd200, 48'h0000_0000_0001, 1, 32'h7180_0000, 0, 0, 48);
    run_op(0, 1, 8'd140, 8'd100, 48'h0ABC_DEF1_2345, 0, '0, 0, 0, 0);
    run_op(0, 0, 8'd127, 8'd127, 48'h1000_0000_0000, 1, 32'h3E80_0000, 0, 0, 4);
    drain();

    // reset while the operation sits in NORM: it must vanish
    run_op(0, 0, 8'd127, 8'd127, 48'h1000_0000_0000, 0, '0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    q.delete();
    chk("rst_norm_out_valid", 64'(out_valid), 64'd0);
    chk("rst_norm_result", 64'({result, overflow, underflow}), 64'd0);
    chk("rst_norm_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_norm_idle", 64'({in_ready, out_valid}), 64'b10);

    // in_valid together with reset: reset wins, nothing is accepted
    sign_a = 0; sign_b = 0; exp_a = 8'd127; exp_b = 8'd127;
    prod = 48'h4000_0000_0000;
    reset = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_valid_idle", 64'({in_ready, out_valid, result}), 64'({1'b1, 1'b0, 32'h0}));

    run_op(1, 1, 8'd130, 8'd120, 48'h6000_0000_0001, 0, '0, 0, 0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
